uart_block_tx: RTL
==================

Name: uart_block_tx

Overview:
Serializes one 128-bit AES result block into a byte stream for the UART_TX byte interface, the transmit-side counterpart of the byte path that feeds plaintext in from UART_RX. It sits between the AES core output and UART_TX in the UART top. It captures a block on a valid strobe, then issues one byte per UART_TX transaction. It waits for UART_TX completion and idle before issuing each next byte.

Parameters:
NUM_BYTES, 16, bytes per block; i_Block width is 8*NUM_BYTES.
CNT_W, 5, width of byte counter; must satisfy 2**CNT_W > NUM_BYTES+1.

Ports:
i_Clk  in  1  system clock, all logic rising-edge.
i_Rst_L  in  1  asynchronous active-low reset.
i_Block_DV  in  1  one-cycle strobe, i_Block valid.
i_Block  in  8*NUM_BYTES  block to send; byte [8*NUM_BYTES-1 -: 8] sent first.
o_Busy  out  1  high from capture until frame complete.
o_Block_Done  out  1  one-cycle pulse after last byte's i_TX_Done.
o_TX_DV  out  1  one-cycle strobe to UART_TX.
o_TX_Byte  out  8  byte to UART_TX, stable from o_TX_DV until i_TX_Done.
i_TX_Active  in  1  UART_TX active.
i_TX_Done  in  1  UART_TX byte done (may stay high more than one cycle).

Behaviour:
- Reset (async assert, sync release): state IDLE, o_Busy=0, o_Block_Done=0, o_TX_DV=0, o_TX_Byte=8'h00, counter=0, shift register=0.
- Reset mid-frame: frame aborted immediately, no further o_TX_DV. A byte already in UART_TX is not recalled.
- FSM states: IDLE, ISSUE, WAIT_DONE, SETTLE, FINISH.
- IDLE: on i_Block_DV, latch i_Block into shift register, counter=0, o_Busy=1, go to ISSUE.
- ISSUE: o_TX_DV=1 for exactly one cycle, o_TX_Byte=current byte, go to WAIT_DONE.
- Latency: i_Block_DV at cycle N gives o_TX_DV at cycle N+1.
- WAIT_DONE: hold o_TX_Byte. On i_TX_Done=1, increment counter and go to SETTLE.
- SETTLE: wait until i_TX_Done=0 and i_TX_Active=0, both sampled in the same cycle. Then go to ISSUE if counter<frame length, else FINISH.
- SETTLE guarantees no o_TX_DV while UART_TX is in cleanup or active.
- FINISH: o_Block_Done=1 for one cycle, o_Busy=0, go to IDLE.
- A new i_Block_DV is accepted in the cycle after FINISH at the earliest.
- i_Block_DV while o_Busy=1 is ignored; the shift register is not disturbed and no error is flagged.
- i_Block_DV in the FINISH cycle is ignored.
- Shift register shifts left by 8 after each byte, so the MSB byte is always next.
- Frame length is NUM_BYTES, or NUM_BYTES+2 with the optional feature.
- Counter is CNT_W bits and never wraps within a frame.
- i_TX_Done seen outside WAIT_DONE is ignored.
- An i_TX_Done edge missed because it lasted under one cycle is not possible: the signal is synchronous to i_Clk.

Optional Feature:
UART_BLK_FRAME_EN
- Defined: frame is sync byte 8'hA5, then NUM_BYTES data bytes, then checksum = XOR of all data bytes. Frame length is NUM_BYTES+2.
- Checksum accumulates as data bytes are issued. The checksum register resets to 8'h00 on capture.
- Undefined: raw NUM_BYTES data bytes only; no sync/checksum logic synthesized.

Test Plan:
- Basic: bench TX model raises Active 1 cycle after DV and pulses Done 10 cycles later. Stimulus i_Block=128'h00112233445566778899AABBCCDDEEFF. Required: 16 o_TX_DV pulses carrying 00,11,...,FF in order; o_Block_Done once after the 16th Done; o_Busy low the next cycle.
- Latency/handshake: o_TX_DV exactly one cycle after i_Block_DV. o_TX_DV never asserted while i_TX_Active=1 or i_TX_Done=1. o_TX_Byte constant between each DV and its Done.
- Busy rejection: second i_Block_DV with 128'hFFFF...FF pulsed at byte 5. Required: output stream still equals the first block; exactly one o_Block_Done.
- Long Done: TX model holds i_TX_Done high 3 cycles. Required: exactly one counter advance per byte; still 16 bytes, no duplicates.
- Reset mid-frame: assert i_Rst_L=0 during byte 7. Required: all outputs go to reset values asynchronously; after release, no o_TX_DV until the next i_Block_DV; the next block is sent completely from byte 0.
- With UART_BLK_FRAME_EN: block 128'h0102030405060708090A0B0C0D0E0F10. Required: 18 bytes: A5, 01..10, then checksum 8'h10.

Source files
------------

// File: rtl/uart_block_tx.sv
// uart_block_tx: serializes a captured AES block into one UART_TX transaction per byte, MSB byte first.
// Define UART_BLK_FRAME_EN to wrap the data in an 8'hA5 sync byte and a trailing XOR checksum.
module uart_block_tx #(
    parameter int NUM_BYTES = 16,
    parameter int CNT_W     = 5
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Block_DV,
    input  logic [8*NUM_BYTES-1:0] i_Block,
    output logic                   o_Busy,
    output logic                   o_Block_Done,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done
);
`ifdef UART_BLK_FRAME_EN
    localparam int LEN = NUM_BYTES + 2;
`else
    localparam int LEN = NUM_BYTES;
`endif
    localparam int TOP = 8*NUM_BYTES - 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, FINISH} state_t;
    state_t state, next;
    logic [8*NUM_BYTES-1:0] shreg;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             cur_byte;
    logic                   is_data;

`ifdef UART_BLK_FRAME_EN
    logic [7:0] chk;
    assign is_data  = (cnt != '0) && (cnt <= CNT_W'(NUM_BYTES));
    assign cur_byte = (cnt == '0) ? 8'hA5 : is_data ? shreg[TOP -: 8] : chk;
`else
    assign is_data  = 1'b1;
    assign cur_byte = shreg[TOP -: 8];
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) state <= IDLE;
        else          state <= next;

    always_comb begin
        next         = state;
        o_TX_DV      = state == ISSUE;
        o_Block_Done = state == FINISH;
        o_Busy       = state == ISSUE || state == WAIT_DONE || state == SETTLE;
        o_TX_Byte    = o_Busy ? cur_byte : 8'h00;
        case (state)
            IDLE:      if (i_Block_DV) next = ISSUE;
            ISSUE:     next = WAIT_DONE;
            WAIT_DONE: if (i_TX_Done) next = SETTLE;
            SETTLE:    if (!i_TX_Done && !i_TX_Active) next = (cnt < CNT_W'(LEN)) ? ISSUE : FINISH;
            FINISH:    next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // Only data bytes consume the shift register; sync and checksum come from elsewhere.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef UART_BLK_FRAME_EN
            chk   <= 8'h00;
`endif
        end else if (state == IDLE && i_Block_DV) begin
            shreg <= i_Block;
            cnt   <= '0;
`ifdef UART_BLK_FRAME_EN
            chk   <= 8'h00;
`endif
        end else if (state == WAIT_DONE && i_TX_Done) begin
            cnt <= cnt + CNT_W'(1);
            if (is_data) begin
                shreg <= shreg << 8;
`ifdef UART_BLK_FRAME_EN
                chk   <= chk ^ shreg[TOP -: 8];
`endif
            end
        end
    end
endmodule
